// File: rtl/bch_syndrome_gen_if.sv
// ---------------------------------------------------------------------------
// bch_syndrome_gen_if
// Bundles the loader-side and solver-side signals of the BCH syndrome
// generator.
//   master : drives set/mode/code, in_valid/idata and out_ready
//            (input loader plus key-equation solver side)
//   slave  : the syndrome generator; drives in_ready, out_valid and results
//
// Handshake: a beat moves on a rising edge where in_valid && in_ready are
// both high. Results move on a rising edge where out_valid && out_ready are
// both high. The source holds its data stable while valid is high and ready
// is low. valid never depends combinationally on ready.
// ---------------------------------------------------------------------------
interface bch_syndrome_gen_if #(
  parameter int P     = 8,
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
);
  logic                       set;
  logic                       mode;
  logic [1:0]                 code;
  logic                       in_valid;
  logic                       in_ready;
  logic [8*P-1:0]             idata;
  logic                       out_valid;
  logic                       out_ready;
  logic [2*T_MAX*M_MAX-1:0]   syn;
  logic                       syn_zero;
  logic [9:0]                 min1_idx;
  logic [9:0]                 min2_idx;

  modport master (
    output set, mode, code, in_valid, idata, out_ready,
    input  in_ready, out_valid, syn, syn_zero, min1_idx, min2_idx
  );

  modport slave (
    input  set, mode, code, in_valid, idata, out_ready,
    output in_ready, out_valid, syn, syn_zero, min1_idx, min2_idx
  );
endinterface

// File: rtl/bch_syndrome_gen.sv
// ---------------------------------------------------------------------------
// bch_syndrome_gen
// Streaming syndrome generator for a GF(2^6/2^8/2^10) BCH code. Each accepted
// beat of P LLRs is folded into S1..S(2*T_MAX) by P-parallel Horner
// evaluation. In soft mode the two least-reliable positions are tracked.
//
// Ports
//   clk         : clock, rising edge
//   rstn        : synchronous active-low reset
//   bus         : slave modport of bch_syndrome_gen_if
//                 (set/mode/code, in_valid/in_ready/idata,
//                  out_valid/out_ready/syn/syn_zero/min1_idx/min2_idx)
//   dbg_state_o : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
// ---------------------------------------------------------------------------
module bch_syndrome_gen #(
  parameter int P     = 8,
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  bch_syndrome_gen_if.slave         bus,
  output logic [1:0]                dbg_state_o
);

  localparam int GW = 10;          // internal GF word, wide enough for m=10
  localparam int NS = 2 * T_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply by alpha in the field picked by c. Bits at and above m stay 0.
  function automatic logic [GW-1:0] mul_alpha(input logic [GW-1:0] a,
                                              input logic [1:0]    c);
    logic [GW-1:0] r;
    r = {a[GW-2:0], 1'b0};
    case (c)
      2'd1: begin
        r = r & 10'h03F;
        if (a[5]) r = r ^ 10'h003;
      end
      2'd2: begin
        r = r & 10'h0FF;
        if (a[7]) r = r ^ 10'h01D;
      end
      default: begin
        if (a[9]) r = r ^ 10'h009;
      end
    endcase
    return r;
  endfunction

  // alpha^e; used only with constant arguments to build coefficient tables.
  function automatic logic [GW-1:0] alpha_pow(input int e, input logic [1:0] c);
    logic [GW-1:0] r;
    r = 10'd1;
    for (int i = 0; i < e; i++) r = mul_alpha(r, c);
    return r;
  endfunction

  // General product a*b, Horner over the bits of b.
  function automatic logic [GW-1:0] gf_mul(input logic [GW-1:0] a,
                                           input logic [GW-1:0] b,
                                           input logic [1:0]    c);
    logic [GW-1:0] r;
    r = '0;
    for (int i = GW - 1; i >= 0; i--) begin
      r = mul_alpha(r, c);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [1:0]             code_q, code_d;
  logic                   first_q, first_d;      // next beat is the frame's first
  logic [9:0]             pos_base_q, pos_base_d; // position of byte 0 of next beat
  logic [NS-1:0][GW-1:0]  syn_q, syn_d, syn_upd;
  logic [7:0]             min1_val_q, min1_val_d, min2_val_q, min2_val_d;
  logic [9:0]             min1_idx_q, min1_idx_d, min2_idx_q, min2_idx_d;

  // Hard decisions; the padding position (top byte of the first beat) is 0.
  logic [P-1:0] hb;
  always_comb begin
    for (int k = 0; k < P; k++) hb[k] = bus.idata[8*k+7];
    if (first_q) hb[P-1] = 1'b0;
  end

  // Per-syndrome Horner step: S_j*alpha^(jP) xor sum_k b_k*alpha^(jk).
  for (genvar j = 1; j <= NS; j++) begin : g_syn
    localparam logic [GW-1:0] STEP1 = alpha_pow(j*P, 2'd1);
    localparam logic [GW-1:0] STEP2 = alpha_pow(j*P, 2'd2);
    localparam logic [GW-1:0] STEP3 = alpha_pow(j*P, 2'd3);
    logic [P-1:0][GW-1:0] pw;
    logic [GW-1:0]        step;
    logic [GW-1:0]        acc;

    for (genvar k = 0; k < P; k++) begin : g_k
      localparam logic [GW-1:0] PW1 = alpha_pow(j*k, 2'd1);
      localparam logic [GW-1:0] PW2 = alpha_pow(j*k, 2'd2);
      localparam logic [GW-1:0] PW3 = alpha_pow(j*k, 2'd3);
      assign pw[k] = (code_q == 2'd1) ? PW1 : (code_q == 2'd2) ? PW2 : PW3;
    end

    always_comb begin
      step = (code_q == 2'd1) ? STEP1 : (code_q == 2'd2) ? STEP2 : STEP3;
      acc  = gf_mul(syn_q[j-1], step, code_q);
      for (int k = 0; k < P; k++) begin
        if (hb[k]) acc = acc ^ pw[k];
      end
    end

    assign syn_upd[j-1] = acc;
  end

  // Min-|LLR| chain across the beat in arrival order (highest byte first).
  // Strict less-than keeps the earlier, higher-index position on ties.
  logic [7:0] c_m1v, c_m2v, mag, byte_v;
  logic [9:0] c_m1i, c_m2i, pos;
  always_comb begin
    c_m1v  = min1_val_q;
    c_m2v  = min2_val_q;
    c_m1i  = min1_idx_q;
    c_m2i  = min2_idx_q;
    mag    = '0;
    byte_v = '0;
    pos    = '0;
    for (int k = P - 1; k >= 0; k--) begin
      byte_v = bus.idata[8*k +: 8];
      if (byte_v == 8'h80)   mag = 8'd127;   // -128 saturates
      else if (byte_v[7])    mag = -byte_v;
      else                   mag = byte_v;
      pos = pos_base_q + 10'(k);
      if (!(first_q && (k == P - 1))) begin
        if (mag < c_m1v) begin
          c_m2v = c_m1v;
          c_m2i = c_m1i;
          c_m1v = mag;
          c_m1i = pos;
        end else if (mag < c_m2v) begin
          c_m2v = mag;
          c_m2i = pos;
        end
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    code_d     = code_q;
    first_d    = first_q;
    pos_base_d = pos_base_q;
    syn_d      = syn_q;
    min1_val_d = min1_val_q;
    min2_val_d = min2_val_q;
    min1_idx_d = min1_idx_q;
    min2_idx_d = min2_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.set && (bus.code != 2'd0)) begin
          state_d    = S_LOAD;
          mode_d     = bus.mode;
          code_d     = bus.code;
          first_d    = 1'b1;
          syn_d      = '0;
          min1_val_d = 8'd128;
          min2_val_d = 8'd128;
          min1_idx_d = '0;
          min2_idx_d = '0;
          case (bus.code)
            2'd1:    pos_base_d = 10'(64 - P);
            2'd2:    pos_base_d = 10'(256 - P);
            default: pos_base_d = 10'(1024 - P);
          endcase
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          syn_d      = syn_upd;
          first_d    = 1'b0;
          pos_base_d = pos_base_q - 10'(P);
          if (mode_q) begin
            min1_val_d = c_m1v;
            min2_val_d = c_m2v;
            min1_idx_d = c_m1i;
            min2_idx_d = c_m2i;
          end
          if (pos_base_q == 10'd0) state_d = S_DONE;  // beat holding position 0
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      code_q     <= 2'd0;
      first_q    <= 1'b0;
      pos_base_q <= '0;
      syn_q      <= '0;
      min1_val_q <= 8'd128;
      min2_val_q <= 8'd128;
      min1_idx_q <= '0;
      min2_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      code_q     <= code_d;
      first_q    <= first_d;
      pos_base_q <= pos_base_d;
      syn_q      <= syn_d;
      min1_val_q <= min1_val_d;
      min2_val_q <= min2_val_d;
      min1_idx_q <= min1_idx_d;
      min2_idx_q <= min2_idx_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.syn_zero  = (state_q == S_DONE) && (syn_q == '0);
  assign bus.min1_idx  = min1_idx_q;
  assign bus.min2_idx  = min2_idx_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    bus.syn = '0;
    for (int j = 0; j < NS; j++) bus.syn[j*M_MAX +: GW] = syn_q[j];
  end

endmodule

// File: doc/bch_syndrome_gen.md
# bch_syndrome_gen

Parametrised, streaming syndrome generator for the BCH decoder. It accepts received LLR beats for a GF(2^6/2^8/2^10) code and computes syndromes S1..S(2·T_MAX) on the fly by P-parallel Horner evaluation, so no 1024-entry symbol store is needed. In soft mode it also tracks the two least-reliable positions for Chase-style decoding. It sits between the input loader and the key-equation solver (Berlekamp stage), and replaces the shift-and-reduce syndrome loop.

## Interface
- P, 8, LLR symbols per input beat; legal values 1, 2, 4, 8.
- T_MAX, 4, max correctable errors; 2·T_MAX syndromes are produced.
- M_MAX, 10, syndrome word width; must be ≥10.
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- set  in  1  start request; sampled in IDLE only.
- mode  in  1  0 = hard, 1 = soft (adds min-|LLR| tracking).
- code  in  2  1: n=63, m=6, x^6+x+1. 2: n=255, m=8, x^8+x^4+x^3+x^2+1. 3: n=1023, m=10, x^10+x^3+1. 0: illegal.
- in_valid  in  1  beat on idata is valid.
- in_ready  out  1  block accepts a beat.
- idata  in  8·P  P signed 8-bit LLRs; byte [8P-1:8P-8] is the highest polynomial index in the beat.
- out_valid  out  1  results valid; held until out_ready.
- out_ready  in  1  consumer accepts results.
- syn  out  2·T_MAX·M_MAX  S_j at bits [j·M_MAX-1:(j-1)·M_MAX], j=1..2T_MAX; bits ≥m are zero.
- syn_zero  out  1  all S_j zero (no detected error).
- min1_idx, min2_idx  out  10 each  positions of smallest / second-smallest |LLR| (soft mode; 0 in hard mode).

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0 and out_valid=0. set=1 with code≠0 latches mode, code and m, clears the accumulators and moves to LOAD. set with code=0 is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready accepts one beat.
  - Total symbols: 2^m (64/256/1024). Beats: 2^m/P.
  - Beats arrive highest index first. The first beat's top byte is position 2^m−1. That position is padding: it is forced to bit 0 and excluded from the min search.
- Hard slice: bit = 1 if the LLR is negative (byte[7]=1), else 0. Both modes use hard bits for the syndromes.
- Syndrome update per beat, for every j: S_j ← S_j·α^(jP) ⊕ Σ_k b_k·α^(j·k), where k=0..P−1 is the offset within the beat.
  - All multiplications are by GF constants in the field selected by code.
  - Result equals r(α^j) with r_i the hard bit at position i.
- Soft tracking: |LLR| is the magnitude, with −128 saturating to 127.
  - Symbols are compared in arrival order, highest index first.
  - Strict less-than replaces, so on ties the earlier (higher-index) position wins.
  - Update: new<min1 → min2←min1, min1←new. Else new<min2 → min2←new.
  - Both minima start at 128 (above any value) before the first symbol.
- After the last beat is accepted: go to DONE with out_valid=1. syn, syn_zero and min*_idx are stable while out_valid=1.
- DONE: out_valid&out_ready → IDLE.
- set outside IDLE is ignored. in_valid outside LOAD is ignored.

## Timing
- Reset values: state IDLE, in_ready=0, out_valid=0, syn=0, syn_zero=0, min1_idx=min2_idx=0.
- set (cycle c, IDLE) → in_ready=1 from c+1.
- Last beat accepted at cycle d → in_ready=0 and out_valid=1 at d+1.
  - With no in_valid gaps, out_valid rises 2^m/P+1 cycles after set.
- in_valid gaps stall Horner updates; no state is lost.
- out_ready may be held low indefinitely; the outputs hold.
- out_valid&out_ready at cycle e → IDLE at e+1. A new set is accepted at e+1 at the earliest.
- rstn=0 in any state returns the block to reset values at the next edge. A partial frame is discarded.

## Test plan
- code=1, hard, 8 beats of all 0x01 → out_valid 9 cycles after set. All S_j=0, syn_zero=1.
- code=1, all positive except the last byte of the last beat = 0x80 (position 0) → every S_j=1, syn_zero=0.
- code=2, single negative LLR at position 5 → S1=α^5=0x20, S2=α^10=0x74. Repeat with the padding byte negative → identical result.
- code=3, soft, all LLR=+50 except pos 700=−3, pos 12=+3, pos 400=+1 → min1_idx=400, min2_idx=700 (tie with 12 keeps the higher index).
- code=2, random in_valid gaps and out_ready low for 20 cycles → syndromes match the gap-free run; outputs stable while stalled.
- rstn pulsed low mid-LOAD, then a new code=1 frame → no out_valid from the aborted frame; the new frame result is correct. set with code=0 → stays IDLE, in_ready=0.
